sramdev_emu: RTL and testbench
==============================

// Module: sramdev_emu
//
// PURPOSE
// Synthesizable, cycle-sampled emulator of the 16-bit asynchronous SRAM that
// our Wishbone-to-SRAM controller drives. It sits on the far side of the
// controller's o_ram_* pins and responds as the memory chip would, backed by
// on-chip block RAM. It also checks strobe protocol and counts accesses, so
// the controller can be exercised on boards with no SRAM fitted and in
// simulation benches.
//
// PARAMETERS
// AW     16  address width of the SRAM pin bus (controller WBADDR+1)
// LGMEM  12  log2 of emulated depth in 16-bit words; address bits [AW-1:LGMEM]
//            are ignored, so the memory aliases. Requires LGMEM <= AW.
// RDLAT  1   read latency in clocks; legal range 1..3
//
// PORTS
// i_clk        in   1   system clock
// i_reset_n    in   1   synchronous reset, active low
// i_ram_ce_n   in   1   chip enable, active low
// i_ram_oe_n   in   1   output enable, active low
// i_ram_we_n   in   1   write enable, active low
// i_ram_addr   in   AW  word address
// i_ram_data   in   16  write data from the controller
// i_ram_sel    in   2   byte-lane enables, active low; [1]=bits 15:8, [0]=7:0
// o_ram_data   out  16  read data toward the controller
// o_ram_drive  out  1   1 = emulator is driving o_ram_data (read data valid)
// o_err        out  3   sticky protocol-error flags
// o_nreads     out  16  read-strobe count, saturates at 16'hffff
// o_nwrites    out  16  write-strobe count, saturates at 16'hffff
//
// BEHAVIOUR
// - All pins are sampled at posedge i_clk; there is no asynchronous path.
// - Reset (i_reset_n=0 at a clock edge):
//   - state<=IDLE, o_ram_data<=0, o_ram_drive<=0, o_err<=0,
//     o_nreads<=0, o_nwrites<=0, read pipeline flushed.
//   - Memory contents are NOT cleared.
// - Cycle classification, per sampled cycle:
//   - rd = !ce_n & !oe_n & we_n
//   - wr = !ce_n & oe_n & !we_n
//   - bad = !ce_n & !oe_n & !we_n
// - FSM states IDLE, READ, WRITE:
//   - IDLE->READ on rd. IDLE->WRITE on wr. Each transition increments the
//     matching counter.
//   - READ/WRITE->IDLE on ce_n=1, or on ce_n=0 with oe_n=we_n=1.
//   - READ->WRITE on wr, or WRITE->READ on rd, with no IDLE cycle between:
//     set o_err[2], take the transition, and count it as a new strobe.
//   - bad in any state: set o_err[0]; no write, no read launch, state unchanged.
// - Write:
//   - Every cycle classified wr, write i_ram_data into
//     mem[i_ram_addr[LGMEM-1:0]] on each lane whose sel bit is 0.
//   - sel=2'b11 writes nothing but still counts as part of the strobe.
//     Repeated cycles with the same data are idempotent.
//   - In WRITE, if i_ram_addr or i_ram_data differs from the previous wr
//     cycle's value: set o_err[1]. The new value is still written.
// - Read:
//   - Each rd cycle launches a read of mem[addr] into a RDLAT-deep pipeline.
//   - RDLAT clocks after the launching edge: o_ram_data = the full 16-bit word
//     (sel is ignored on reads) and o_ram_drive=1.
//   - Pipeline slots not launched by rd give o_ram_drive=0; o_ram_data then
//     holds its last value.
//   - Read-during-write to the same address across cycles returns the newly
//     written data, since the write completes before the later read launches.
// - Counters saturate at 16'hffff (no wrap).
// - o_err bits are sticky; only reset clears them.
// - Reset mid-strobe: the strobe is abandoned. If pins are still active at the
//   first edge after release, that edge starts a new strobe and is counted.
//
// TESTING
// 1 Write 16'hbeef @16'h0010, sel=00, 2 wr cycles; ce_n=1 one cycle; rd
//   @16'h0010 -> o_ram_data=16'hbeef, o_ram_drive=1 RDLAT clocks later;
//   o_nwrites=1, o_nreads=1, o_err=0.
// 2 Preload 16'h1234 @16'h0020; write 16'habcd sel=2'b10 -> read gives
//   16'h12cd. Repeat with sel=2'b01 -> 16'habcd. sel=2'b11 -> unchanged.
// 3 LGMEM=12: write 16'h5a5a @16'h1005 -> read @16'h0005 gives 16'h5a5a.
// 4 Drive ce_n=oe_n=we_n=0 @16'h0030 (holds 16'h7777) -> o_err[0]=1,
//   o_ram_drive=0, later read still 16'h7777.
// 5 rd then wr with ce_n held low -> o_err[2]=1, o_nwrites=1, o_nreads=1.
//   In a separate run, change addr mid-write -> o_err[1]=1.
// 6 Controller-style 32-bit access: upper half @2n, ce_n high 1 clk, lower
//   half @2n+1. Then assert reset during the second write half -> counters=0,
//   o_err=0, and the first-half word is retained on readback.

Source files
------------

// File: rtl/sramdev_emu.sv
// Cycle-sampled emulator of a 16-bit asynchronous SRAM behind a block RAM,
// with strobe-protocol checking and saturating access counters.
module sramdev_emu #(
    parameter int AW    = 16,
    parameter int LGMEM = 12,
    parameter int RDLAT = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ram_ce_n,
    input  logic          i_ram_oe_n,
    input  logic          i_ram_we_n,
    input  logic [AW-1:0] i_ram_addr,
    input  logic [15:0]   i_ram_data,
    input  logic [1:0]    i_ram_sel,
    output logic [15:0]   o_ram_data,
    output logic          o_ram_drive,
    output logic [2:0]    o_err,
    output logic [15:0]   o_nreads,
    output logic [15:0]   o_nwrites
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t           state_q, state_d;
    logic             rd, wr, bad;
    logic             mem_we;
    logic [LGMEM-1:0] idx;

    logic [15:0]      mem [1<<LGMEM];
    logic [15:0]      pipe_q [RDLAT];
    logic [RDLAT-1:0] vld_q, vld_d;

    logic [15:0]      ram_data_q, ram_data_d;
    logic             drive_q, drive_d;
    logic [2:0]       err_q, err_d;
    logic [15:0]      nreads_q, nreads_d;
    logic [15:0]      nwrites_q, nwrites_d;
    logic [AW-1:0]    prev_addr_q, prev_addr_d;
    logic [15:0]      prev_data_q, prev_data_d;

    always_comb begin
        rd     = !i_ram_ce_n && !i_ram_oe_n &&  i_ram_we_n;
        wr     = !i_ram_ce_n &&  i_ram_oe_n && !i_ram_we_n;
        bad    = !i_ram_ce_n && !i_ram_oe_n && !i_ram_we_n;
        idx    = i_ram_addr[LGMEM-1:0];
        mem_we = wr && i_reset_n;
    end

    // Strobe tracking: a strobe begins whenever the access kind changes
    // without an idle cycle in between, so turnarounds still count.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        nreads_d    = nreads_q;
        nwrites_d   = nwrites_q;
        prev_addr_d = prev_addr_q;
        prev_data_d = prev_data_q;
        ram_data_d  = ram_data_q;
        drive_d     = vld_q[RDLAT-1];
        vld_d       = vld_q << 1;
        vld_d[0]    = rd;

        if (vld_q[RDLAT-1]) begin
            ram_data_d = pipe_q[RDLAT-1];
        end

        if (bad) begin
            err_d[0] = 1'b1;
        end else if (rd) begin
            if (state_q != READ) begin
                if (nreads_q != 16'hffff) nreads_d = nreads_q + 16'd1;
                if (state_q == WRITE) err_d[2] = 1'b1;
            end
            state_d = READ;
        end else if (wr) begin
            if (state_q != WRITE) begin
                if (nwrites_q != 16'hffff) nwrites_d = nwrites_q + 16'd1;
                if (state_q == READ) err_d[2] = 1'b1;
            end else if (i_ram_addr != prev_addr_q || i_ram_data != prev_data_q) begin
                err_d[1] = 1'b1;
            end
            prev_addr_d = i_ram_addr;
            prev_data_d = i_ram_data;
            state_d     = WRITE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            err_q       <= 3'b000;
            nreads_q    <= 16'h0000;
            nwrites_q   <= 16'h0000;
            prev_addr_q <= '0;
            prev_data_q <= 16'h0000;
            ram_data_q  <= 16'h0000;
            drive_q     <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            nreads_q    <= nreads_d;
            nwrites_q   <= nwrites_d;
            prev_addr_q <= prev_addr_d;
            prev_data_q <= prev_data_d;
            ram_data_q  <= ram_data_d;
            drive_q     <= drive_d;
            vld_q       <= vld_d;
        end
    end

    // Storage survives reset; the data pipeline shifts freely and only the
    // valid bits decide what reaches the pins.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            if (!i_ram_sel[0]) mem[idx][7:0]  <= i_ram_data[7:0];
            if (!i_ram_sel[1]) mem[idx][15:8] <= i_ram_data[15:8];
        end
        pipe_q[0] <= mem[idx];
        for (int i = 1; i < RDLAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign o_ram_data  = ram_data_q;
    assign o_ram_drive = drive_q;
    assign o_err       = err_q;
    assign o_nreads    = nreads_q;
    assign o_nwrites   = nwrites_q;

endmodule

// File: tb/tb_sramdev_emu.sv
// Self-checking bench for sramdev_emu: directed scenarios plus randomized
// traffic compared against an array/queue model of the SRAM behaviour.
module tb_sramdev_emu;

    localparam int AW    = 16;
    localparam int LGMEM = 12;
    localparam int RDLAT = 2;
    localparam int MEMW  = 1 << LGMEM;

    typedef struct {
        bit          v;
        logic [15:0] d;
    } launch_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce_n, oe_n, we_n;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    sel;
    logic [15:0]   o_ram_data;
    logic          o_ram_drive;
    logic [2:0]    o_err;
    logic [15:0]   o_nreads, o_nwrites;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_mem [MEMW];
    int          m_kind;
    logic [AW-1:0] m_paddr;
    logic [15:0] m_pdata;
    logic [15:0] m_nr, m_nw, m_data;
    logic [2:0]  m_err;
    bit          m_drive;
    launch_t     lq[$];

    sramdev_emu #(.AW(AW), .LGMEM(LGMEM), .RDLAT(RDLAT)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_ram_ce_n (ce_n),
        .i_ram_oe_n (oe_n),
        .i_ram_we_n (we_n),
        .i_ram_addr (addr),
        .i_ram_data (wdata),
        .i_ram_sel  (sel),
        .o_ram_data (o_ram_data),
        .o_ram_drive(o_ram_drive),
        .o_err      (o_err),
        .o_nreads   (o_nreads),
        .o_nwrites  (o_nwrites)
    );

    always #5 clk = ~clk;

    // Reference: kind of the last strobe (0 none, 1 read, 2 write), a word
    // array, and a queue of read launches that emerge RDLAT edges later.
    task automatic model_edge();
        launch_t e;
        bit r, w, b;
        int i;
        if (!rst_n) begin
            m_kind = 0; m_nr = 0; m_nw = 0; m_err = 0;
            m_data = 0; m_drive = 0;
            lq.delete();
            return;
        end
        e.v = 0; e.d = 16'h0000;
        r = !ce_n && !oe_n &&  we_n;
        w = !ce_n &&  oe_n && !we_n;
        b = !ce_n && !oe_n && !we_n;
        i = int'(addr) % MEMW;
        if (b) begin
            m_err[0] = 1'b1;
        end else if (r) begin
            if (m_kind != 1) begin
                if (m_nr != 16'hffff) m_nr = m_nr + 1;
                if (m_kind == 2) m_err[2] = 1'b1;
            end
            m_kind = 1;
            e.v = 1; e.d = m_mem[i];
        end else if (w) begin
            if (m_kind != 2) begin
                if (m_nw != 16'hffff) m_nw = m_nw + 1;
                if (m_kind == 1) m_err[2] = 1'b1;
            end else if (addr != m_paddr || wdata != m_pdata) begin
                m_err[1] = 1'b1;
            end
            m_paddr = addr; m_pdata = wdata;
            if (!sel[0]) m_mem[i][7:0]  = wdata[7:0];
            if (!sel[1]) m_mem[i][15:8] = wdata[15:8];
            m_kind = 2;
        end else begin
            m_kind = 0;
        end
        lq.push_back(e);
        m_drive = 0;
        if (lq.size() > RDLAT) begin
            e = lq.pop_front();
            m_drive = e.v;
            if (e.v) m_data = e.d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pins_idle();
        ce_n = 1; oe_n = 1; we_n = 1;
    endtask

    task automatic pins_rd(input logic [AW-1:0] a);
        ce_n = 0; oe_n = 0; we_n = 1; addr = a;
    endtask

    task automatic pins_wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] s);
        ce_n = 0; oe_n = 1; we_n = 0; addr = a; wdata = d; sel = s;
    endtask

    task automatic do_reset();
        pins_idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] s);
        pins_wr(a, d, s);
        tick();
        tick();
        pins_idle();
        tick();
    endtask

    task automatic read_word(input logic [AW-1:0] a);
        pins_rd(a);
        tick();
        pins_idle();
        repeat (RDLAT) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_err !== 3'b000) begin n_errors++; $display("[TB] FAIL reset_err got %b want 000", o_err); end
        n_checks++; if (o_nreads !== 16'h0) begin n_errors++; $display("[TB] FAIL reset_nreads got %h want 0000", o_nreads); end
        n_checks++; if (o_nwrites !== 16'h0) begin n_errors++; $display("[TB] FAIL reset_nwrites got %h want 0000", o_nwrites); end
        n_checks++; if (o_ram_drive !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_drive got %b want 0", o_ram_drive); end
        n_checks++; if (o_ram_data !== 16'h0) begin n_errors++; $display("[TB] FAIL reset_data got %h want 0000", o_ram_data); end
    endtask

    task automatic test_basic();
        do_reset();
        pins_wr(16'h0010, 16'hbeef, 2'b00);
        tick(); tick();
        pins_idle();
        tick();
        pins_rd(16'h0010);
        tick();
        pins_idle();
        for (int i = 1; i <= RDLAT; i++) begin
            tick();
            n_checks++;
            if (o_ram_drive !== (i == RDLAT)) begin
                n_errors++; $display("[TB] FAIL basic_latency step %0d drive got %b want %b", i, o_ram_drive, (i == RDLAT));
            end
        end
        n_checks++; if (o_ram_data !== 16'hbeef) begin n_errors++; $display("[TB] FAIL basic_data got %h want beef", o_ram_data); end
        n_checks++; if (o_nwrites !== 16'd1) begin n_errors++; $display("[TB] FAIL basic_nwrites got %0d want 1", o_nwrites); end
        n_checks++; if (o_nreads !== 16'd1) begin n_errors++; $display("[TB] FAIL basic_nreads got %0d want 1", o_nreads); end
        n_checks++; if (o_err !== 3'b000) begin n_errors++; $display("[TB] FAIL basic_err got %b want 000", o_err); end
        tick();
        n_checks++; if (o_ram_drive !== 1'b0 || o_ram_data !== 16'hbeef) begin
            n_errors++; $display("[TB] FAIL basic_hold drive %b data %h want 0 beef", o_ram_drive, o_ram_data);
        end
    endtask

    task automatic test_byte_lanes();
        do_reset();
        write_word(16'h0020, 16'h1234, 2'b00);
        write_word(16'h0020, 16'habcd, 2'b10);
        read_word(16'h0020);
        n_checks++; if (o_ram_data !== 16'h12cd) begin n_errors++; $display("[TB] FAIL lane_low got %h want 12cd", o_ram_data); end
        write_word(16'h0020, 16'habcd, 2'b01);
        read_word(16'h0020);
        n_checks++; if (o_ram_data !== 16'habcd) begin n_errors++; $display("[TB] FAIL lane_high got %h want abcd", o_ram_data); end
        write_word(16'h0020, 16'h0000, 2'b11);
        read_word(16'h0020);
        n_checks++; if (o_ram_data !== 16'habcd || o_ram_drive !== 1'b1) begin
            n_errors++; $display("[TB] FAIL lane_none data %h drive %b want abcd 1", o_ram_data, o_ram_drive);
        end
        n_checks++; if (o_nwrites !== 16'd4) begin n_errors++; $display("[TB] FAIL lane_nwrites got %0d want 4", o_nwrites); end
    endtask

    task automatic test_alias();
        write_word(16'h1005, 16'h5a5a, 2'b00);
        read_word(16'h0005);
        n_checks++; if (o_ram_data !== 16'h5a5a) begin n_errors++; $display("[TB] FAIL alias got %h want 5a5a", o_ram_data); end
    endtask

    task automatic test_bad();
        do_reset();
        write_word(16'h0030, 16'h7777, 2'b00);
        ce_n = 0; oe_n = 0; we_n = 0; addr = 16'h0030; wdata = 16'h0000; sel = 2'b00;
        tick();
        pins_idle();
        for (int i = 0; i <= RDLAT; i++) begin
            tick();
            n_checks++; if (o_ram_drive !== 1'b0) begin n_errors++; $display("[TB] FAIL bad_drive step %0d got %b want 0", i, o_ram_drive); end
        end
        n_checks++; if (o_err !== 3'b001) begin n_errors++; $display("[TB] FAIL bad_err got %b want 001", o_err); end
        n_checks++; if (o_nwrites !== 16'd1 || o_nreads !== 16'd0) begin
            n_errors++; $display("[TB] FAIL bad_counts nw %0d nr %0d want 1 0", o_nwrites, o_nreads);
        end
        read_word(16'h0030);
        n_checks++; if (o_ram_data !== 16'h7777) begin n_errors++; $display("[TB] FAIL bad_mem got %h want 7777", o_ram_data); end
    endtask

    task automatic test_turnaround();
        do_reset();
        pins_rd(16'h0040);
        tick();
        pins_wr(16'h0040, 16'h1111, 2'b00);
        tick();
        pins_idle();
        tick();
        n_checks++; if (o_err !== 3'b100) begin n_errors++; $display("[TB] FAIL turn_err got %b want 100", o_err); end
        n_checks++; if (o_nwrites !== 16'd1 || o_nreads !== 16'd1) begin
            n_errors++; $display("[TB] FAIL turn_counts nw %0d nr %0d want 1 1", o_nwrites, o_nreads);
        end
        do_reset();
        n_checks++; if (o_err !== 3'b000) begin n_errors++; $display("[TB] FAIL sticky_clear got %b want 000", o_err); end
        pins_wr(16'h0050, 16'h2222, 2'b00);
        tick();
        pins_wr(16'h0051, 16'h3333, 2'b00);
        tick();
        pins_idle();
        tick();
        n_checks++; if (o_err !== 3'b010 || o_nwrites !== 16'd1) begin
            n_errors++; $display("[TB] FAIL addr_change err %b nw %0d want 010 1", o_err, o_nwrites);
        end
        read_word(16'h0051);
        n_checks++; if (o_ram_data !== 16'h3333) begin n_errors++; $display("[TB] FAIL addr_change_new got %h want 3333", o_ram_data); end
        read_word(16'h0050);
        n_checks++; if (o_ram_data !== 16'h2222) begin n_errors++; $display("[TB] FAIL addr_change_old got %h want 2222", o_ram_data); end
    endtask

    task automatic test_wide_and_reset();
        do_reset();
        pins_wr(16'h0100, 16'hcafe, 2'b00);
        tick(); tick();
        pins_idle();
        tick();
        pins_wr(16'h0101, 16'hf00d, 2'b00);
        tick(); tick();
        pins_idle();
        tick();
        read_word(16'h0100);
        n_checks++; if (o_ram_data !== 16'hcafe) begin n_errors++; $display("[TB] FAIL wide_hi got %h want cafe", o_ram_data); end
        read_word(16'h0101);
        n_checks++; if (o_ram_data !== 16'hf00d) begin n_errors++; $display("[TB] FAIL wide_lo got %h want f00d", o_ram_data); end
        pins_wr(16'h0200, 16'h1357, 2'b00);
        tick(); tick();
        pins_idle();
        tick();
        pins_wr(16'h0201, 16'h2468, 2'b00);
        tick();
        rst_n = 0;
        tick();
        n_checks++; if (o_nreads !== 16'd0 || o_nwrites !== 16'd0 || o_err !== 3'b000) begin
            n_errors++; $display("[TB] FAIL midreset nr %0d nw %0d err %b want 0 0 000", o_nreads, o_nwrites, o_err);
        end
        rst_n = 1;
        tick();
        n_checks++; if (o_nwrites !== 16'd1) begin n_errors++; $display("[TB] FAIL restart_count got %0d want 1", o_nwrites); end
        pins_idle();
        tick();
        read_word(16'h0200);
        n_checks++; if (o_ram_data !== 16'h1357 || o_err !== 3'b000) begin
            n_errors++; $display("[TB] FAIL retained data %h err %b want 1357 000", o_ram_data, o_err);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [8];
        int k;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pool[i] = AW'(16'h0300 + i * 37);
            write_word(pool[i], 16'($urandom), 2'b00);
        end
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 39);
            if (k < 12) begin
                pins_idle();
            end else if (k < 24) begin
                pins_rd({4'($urandom), pool[$urandom_range(0, 7)][11:0]});
            end else if (k < 38) begin
                if (k < 32 || we_n) begin
                    pins_wr({4'($urandom), pool[$urandom_range(0, 7)][11:0]}, 16'($urandom), 2'($urandom));
                end
            end else begin
                ce_n = 0; oe_n = 0; we_n = 0;
            end
            tick();
            n_checks++;
            if (o_ram_drive !== m_drive || o_ram_data !== m_data || o_err !== m_err ||
                o_nreads !== m_nr || o_nwrites !== m_nw) begin
                n_errors++;
                $display("[TB] FAIL random cyc %0d got drv %b data %h err %b nr %0d nw %0d want %b %h %b %0d %0d",
                         n, o_ram_drive, o_ram_data, o_err, o_nreads, o_nwrites,
                         m_drive, m_data, m_err, m_nr, m_nw);
            end
        end
        pins_idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < MEMW; i++) m_mem[i] = 16'h0000;
        m_kind = 0; m_paddr = '0; m_pdata = 0;
        m_nr = 0; m_nw = 0; m_data = 0; m_err = 0; m_drive = 0;
        rst_n = 0;
        pins_idle();
        addr = '0; wdata = 16'h0000; sel = 2'b00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_byte_lanes();
        test_alias();
        test_bad();
        test_turnaround();
        test_wide_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
